// File: rtl/bp_cce_inv_sequencer_pkg.sv
// Shared types for the CCE invalidation sequencer: coherence states,
// sequencer FSM states and a small population-count helper.
package bp_cce_inv_sequencer_pkg;

  typedef enum logic [2:0] {
    e_COH_I = 3'b000,
    e_COH_S = 3'b001,
    e_COH_E = 3'b010,
    e_COH_F = 3'b011,
    e_COH_M = 3'b110,
    e_COH_O = 3'b111
  } bp_coh_states_e;

  typedef enum logic [1:0] {
    e_ready,
    e_send,
    e_wait,
    e_done
  } bp_cce_inv_state_e;

  // Number of set bits; callers zero-extend narrower vectors to 64 bits.
  function automatic int unsigned popcount(input logic [63:0] v);
    int unsigned c;
    c = 0;
    for (int unsigned i = 0; i < 64; i++) begin
      c = c + {31'b0, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/bp_cce_inv_sequencer_if.sv
// Snapshot / invalidate-command / ack / done signalling between the CCE
// and the invalidation sequencer. slave = sequencer side.
interface bp_cce_inv_sequencer_if
  import bp_cce_inv_sequencer_pkg::*;
#(
  parameter int num_lce_p         = 8,
  parameter int lce_id_width_p    = 3,
  parameter int lce_assoc_width_p = 3,
  parameter int paddr_width_p     = 40
);
  localparam int coh_w_lp = $bits(bp_coh_states_e);
  localparam int cnt_w_lp = $clog2(num_lce_p + 1);

  logic                                       start_v_i;
  logic                                       start_ready_and_o;
  logic [paddr_width_p-1:0]                   addr_i;
  logic [lce_id_width_p-1:0]                  req_lce_i;
  logic [num_lce_p-1:0]                       sharers_hits_i;
  logic [num_lce_p*lce_assoc_width_p-1:0]     sharers_ways_i;
  logic [num_lce_p*coh_w_lp-1:0]              sharers_coh_states_i;
  logic                                       inv_v_o;
  logic                                       inv_ready_and_i;
  logic [lce_id_width_p-1:0]                  inv_lce_o;
  logic [lce_assoc_width_p-1:0]               inv_way_o;
  logic [paddr_width_p-1:0]                   inv_addr_o;
  logic                                       ack_v_i;
  logic [lce_id_width_p-1:0]                  ack_lce_i;
  logic                                       ack_yumi_o;
  logic                                       done_v_o;
  logic                                       done_yumi_i;
  logic [cnt_w_lp-1:0]                        inv_count_o;
  logic                                       busy_o;

  modport slave (
    input  start_v_i, addr_i, req_lce_i, sharers_hits_i, sharers_ways_i,
           sharers_coh_states_i, inv_ready_and_i, ack_v_i, ack_lce_i, done_yumi_i,
    output start_ready_and_o, inv_v_o, inv_lce_o, inv_way_o, inv_addr_o,
           ack_yumi_o, done_v_o, inv_count_o, busy_o
  );

  modport master (
    output start_v_i, addr_i, req_lce_i, sharers_hits_i, sharers_ways_i,
           sharers_coh_states_i, inv_ready_and_i, ack_v_i, ack_lce_i, done_yumi_i,
    input  start_ready_and_o, inv_v_o, inv_lce_o, inv_way_o, inv_addr_o,
           ack_yumi_o, done_v_o, inv_count_o, busy_o
  );

endinterface

// File: rtl/bp_cce_inv_sequencer_penc.sv
// Lowest-set-bit priority encoder: index of the first 1 from bit 0, plus valid.
module bp_cce_inv_sequencer_penc #(
  parameter int width_p     = 8,
  parameter int idx_width_p = 3
) (
  input  logic [width_p-1:0]     i_bits,
  output logic [idx_width_p-1:0] o_idx,
  output logic                   o_v
);

  // Scan upward; the first hit wins and later bits are ignored.
  always_comb begin
    o_idx = '0;
    o_v   = 1'b0;
    for (int unsigned i = 0; i < width_p; i++) begin
      if (i_bits[i] && !o_v) begin
        o_idx = idx_width_p'(i);
        o_v   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bp_cce_inv_sequencer.sv
// CCE invalidation sequencer: takes one directory sharers snapshot, sends one
// invalidate per sharing LCE (lowest ID first), collects acks, then reports done.
module bp_cce_inv_sequencer
  import bp_cce_inv_sequencer_pkg::*;
#(
  parameter int num_lce_p         = 8,
  parameter int lce_id_width_p    = 3,
  parameter int lce_assoc_width_p = 3,
  parameter int paddr_width_p     = 40
) (
  input logic                    clk_i,
  input logic                    reset_i,
  bp_cce_inv_sequencer_if.slave  bus
);

  localparam int coh_w_lp = $bits(bp_coh_states_e);
  localparam int cnt_w_lp = $clog2(num_lce_p + 1);

  bp_cce_inv_state_e                      r_state, w_state_n;
  logic [num_lce_p-1:0]                   r_send_mask, w_send_mask_n;
  logic [num_lce_p-1:0]                   r_pend_mask, w_pend_mask_n;
  logic [num_lce_p-1:0]                   w_start_mask;
  logic [num_lce_p*lce_assoc_width_p-1:0] r_ways;
  logic [paddr_width_p-1:0]               r_addr;
  logic [cnt_w_lp-1:0]                    r_count;
  logic [lce_id_width_p-1:0]              w_sel_lce;
  logic                                   w_sel_v;
  logic                                   w_start_hs, w_send_hs, w_ack_hs;

  bp_cce_inv_sequencer_penc #(
    .width_p     (num_lce_p),
    .idx_width_p (lce_id_width_p)
  ) u_penc (
    .i_bits (r_send_mask),
    .o_idx  (w_sel_lce),
    .o_v    (w_sel_v)
  );

  // Snapshot filter: hit, not the requestor, and held in a valid state.
  always_comb begin
    w_start_mask = '0;
    for (int unsigned i = 0; i < num_lce_p; i++) begin
      w_start_mask[i] = bus.sharers_hits_i[i]
                        && (bus.req_lce_i != lce_id_width_p'(i))
                        && (bp_coh_states_e'(bus.sharers_coh_states_i[i*coh_w_lp +: coh_w_lp]) != e_COH_I);
    end
  end

  // Handshakes and outward signals derived from the current state.
  always_comb begin
    bus.start_ready_and_o = (r_state == e_ready);
    bus.inv_v_o           = (r_state == e_send) && w_sel_v;
    bus.inv_lce_o         = w_sel_lce;
    bus.inv_way_o         = r_ways[w_sel_lce*lce_assoc_width_p +: lce_assoc_width_p];
    bus.inv_addr_o        = r_addr;
    bus.ack_yumi_o        = bus.ack_v_i && ((r_state == e_send) || (r_state == e_wait));
    bus.done_v_o          = (r_state == e_done);
    bus.inv_count_o       = r_count;
    bus.busy_o            = (r_state != e_ready);
    w_start_hs            = bus.start_v_i && bus.start_ready_and_o;
    w_send_hs             = bus.inv_v_o && bus.inv_ready_and_i;
    w_ack_hs              = bus.ack_yumi_o;
  end

  // Next state and mask updates; an ack and a send in the same cycle both apply.
  always_comb begin
    w_state_n     = r_state;
    w_send_mask_n = r_send_mask;
    w_pend_mask_n = r_pend_mask;
    case (r_state)
      e_ready: begin
        if (bus.start_v_i) begin
          w_send_mask_n = w_start_mask;
          w_pend_mask_n = '0;
          w_state_n     = (w_start_mask == '0) ? e_done : e_send;
        end
      end
      e_send: begin
        if (w_ack_hs) w_pend_mask_n[bus.ack_lce_i] = 1'b0;
        if (w_send_hs) begin
          w_send_mask_n[w_sel_lce] = 1'b0;
          w_pend_mask_n[w_sel_lce] = 1'b1;
        end
        if (w_send_mask_n == '0) w_state_n = e_wait;
      end
      e_wait: begin
        if (w_ack_hs) w_pend_mask_n[bus.ack_lce_i] = 1'b0;
        if (w_pend_mask_n == '0) w_state_n = e_done;
      end
      e_done: begin
        if (bus.done_yumi_i) w_state_n = e_ready;
      end
      default: w_state_n = e_ready;
    endcase
  end

  // State, masks and latched snapshot fields; count held until the next start.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state     <= e_ready;
      r_send_mask <= '0;
      r_pend_mask <= '0;
      r_ways      <= '0;
      r_addr      <= '0;
      r_count     <= '0;
    end else begin
      r_state     <= w_state_n;
      r_send_mask <= w_send_mask_n;
      r_pend_mask <= w_pend_mask_n;
      if (w_start_hs) begin
        r_ways  <= bus.sharers_ways_i;
        r_addr  <= bus.addr_i;
        r_count <= cnt_w_lp'(popcount(64'(w_start_mask)));
      end
    end
  end

  // Acks from LCEs with nothing outstanding are consumed and dropped.
  a_ack_pending: assert property (@(posedge clk_i) disable iff (reset_i)
    w_ack_hs |-> r_pend_mask[bus.ack_lce_i])
    else $warning("inv_sequencer: ack from LCE %0d with no outstanding invalidate ignored", bus.ack_lce_i);

  a_ack_not_sending: assert property (@(posedge clk_i) disable iff (reset_i)
    (w_send_hs && w_ack_hs) |-> (bus.ack_lce_i != w_sel_lce))
    else $error("inv_sequencer: ack targets the LCE being invalidated this cycle");

endmodule

// File: tb/tb_bp_cce_inv_sequencer.sv
// Bench for bp_cce_inv_sequencer: snapshot vectors from a table, expected
// invalidates queued at start and popped as the DUT issues them.
module tb_bp_cce_inv_sequencer;
  import bp_cce_inv_sequencer_pkg::*;

  localparam int N = 8, IDW = 3, WW = 3, AW = 40;
  localparam logic [23:0] ALL_S = 24'h249249;
  localparam logic [23:0] WAYS  = {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};

  typedef struct {
    logic [7:0]  hits;
    logic [2:0]  req;
    logic [23:0] states;
    logic [23:0] ways;
    logic [39:0] addr;
    int          exp_count;
    int          stall_lce;
    int          ovl_send;
    logic [2:0]  ovl_ack;
    bit          spur;
    int          n_acks;
    logic [23:0] acks;
  } vec_t;

  typedef struct {
    logic [2:0]  lce;
    logic [2:0]  way;
    logic [39:0] addr;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bp_cce_inv_sequencer_if #(.num_lce_p(N), .lce_id_width_p(IDW),
                            .lce_assoc_width_p(WW), .paddr_width_p(AW)) bus();

  bp_cce_inv_sequencer #(.num_lce_p(N), .lce_id_width_p(IDW),
                         .lce_assoc_width_p(WW), .paddr_width_p(AW)) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (bus)
  );

  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb_q[$];
  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected invalidates: every sharing LCE other than the requestor, ascending ID.
  function automatic void push_expected(input vec_t v);
    exp_t e;
    for (int i = 0; i < N; i++) begin
      if (v.hits[i] && (i != int'(v.req)) && (v.states[i*3 +: 3] != 3'b000)) begin
        e.lce  = 3'(i);
        e.way  = v.ways[i*3 +: 3];
        e.addr = v.addr;
        sb_q.push_back(e);
      end
    end
  endfunction

  // Scoreboard monitor: every offered invalidate must match the queue head.
  always @(negedge clk) begin
    if (!rst && bus.inv_v_o) begin
      if (sb_q.size() == 0) begin
        check("inv_unexpected", 64'(bus.inv_v_o), 64'(0));
      end else begin
        check("inv_lce",  64'(bus.inv_lce_o),  64'(sb_q[0].lce));
        check("inv_way",  64'(bus.inv_way_o),  64'(sb_q[0].way));
        check("inv_addr", 64'(bus.inv_addr_o), 64'(sb_q[0].addr));
        if (bus.inv_ready_and_i) void'(sb_q.pop_front());
      end
    end
  end

  task automatic run_vec(input vec_t v, input bit abort);
    int guard;
    int stalls;
    check("start_ready", 64'(bus.start_ready_and_o), 64'(1));
    push_expected(v);
    bus.start_v_i            = 1'b1;
    bus.addr_i               = v.addr;
    bus.req_lce_i            = v.req;
    bus.sharers_hits_i       = v.hits;
    bus.sharers_ways_i       = v.ways;
    bus.sharers_coh_states_i = v.states;
    @(posedge clk); #1;
    bus.start_v_i = 1'b0;
    check("inv_count",   64'(bus.inv_count_o), 64'(v.exp_count));
    check("busy_start",  64'(bus.busy_o), 64'(1));
    check("inv_v_first", 64'(bus.inv_v_o), 64'(v.exp_count != 0));
    check("done_zero",   64'(bus.done_v_o), 64'(v.exp_count == 0));

    stalls = 3;
    guard  = 0;
    while (bus.inv_v_o && guard < 60) begin
      bus.inv_ready_and_i = !((v.stall_lce == int'(bus.inv_lce_o)) && stalls > 0);
      if (!bus.inv_ready_and_i) stalls--;
      if ((v.ovl_send == int'(bus.inv_lce_o)) && bus.inv_ready_and_i) begin
        bus.ack_v_i   = 1'b1;
        bus.ack_lce_i = v.ovl_ack;
        #1;
        check("ack_yumi_ovl", 64'(bus.ack_yumi_o), 64'(1));
      end
      @(posedge clk); #1;
      bus.ack_v_i = 1'b0;
      guard++;
    end
    bus.inv_ready_and_i = 1'b0;
    check("send_timeout", 64'(guard >= 60), 64'(0));
    check("sb_drained", 64'(sb_q.size()), 64'(0));
    if (v.stall_lce >= 0) check("stall_seen", 64'(stalls), 64'(0));

    if (abort) begin
      check("wait_busy", 64'(bus.busy_o), 64'(1));
      check("wait_done", 64'(bus.done_v_o), 64'(0));
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("abort_busy",  64'(bus.busy_o), 64'(0));
      check("abort_done",  64'(bus.done_v_o), 64'(0));
      check("abort_ready", 64'(bus.start_ready_and_o), 64'(1));
      check("abort_count", 64'(bus.inv_count_o), 64'(0));
      repeat (3) begin
        @(posedge clk); #1;
        check("abort_no_inv", 64'(bus.inv_v_o), 64'(0));
      end
      sb_q.delete();
      return;
    end

    if (v.spur) begin
      bus.ack_v_i   = 1'b1;
      bus.ack_lce_i = 3'd0;
      #1;
      check("spur_yumi", 64'(bus.ack_yumi_o), 64'(1));
      @(posedge clk); #1;
      bus.ack_v_i = 1'b0;
      check("spur_done", 64'(bus.done_v_o), 64'(0));
      check("spur_busy", 64'(bus.busy_o), 64'(1));
    end

    for (int k = 0; k < v.n_acks; k++) begin
      bus.ack_v_i   = 1'b1;
      bus.ack_lce_i = v.acks[3*k +: 3];
      #1;
      check("ack_yumi", 64'(bus.ack_yumi_o), 64'(1));
      @(posedge clk); #1;
      bus.ack_v_i = 1'b0;
      check(k == v.n_acks - 1 ? "done_after_last_ack" : "done_early",
            64'(bus.done_v_o), 64'(k == v.n_acks - 1));
    end

    check("done_v", 64'(bus.done_v_o), 64'(1));
    bus.ack_v_i   = 1'b1;
    bus.ack_lce_i = 3'd0;
    #1;
    check("ack_yumi_in_done", 64'(bus.ack_yumi_o), 64'(0));
    bus.ack_v_i     = 1'b0;
    bus.done_yumi_i = 1'b1;
    @(posedge clk); #1;
    bus.done_yumi_i = 1'b0;
    check("done_clear",  64'(bus.done_v_o), 64'(0));
    check("idle_busy",   64'(bus.busy_o), 64'(0));
    check("idle_ready",  64'(bus.start_ready_and_o), 64'(1));
    check("count_held",  64'(bus.inv_count_o), 64'(v.exp_count));
  endtask

  initial begin
    vecs[0] = '{hits:8'h00, req:3'd0, states:ALL_S, ways:WAYS, addr:40'h00_0000_1000,
                exp_count:0, stall_lce:-1, ovl_send:-1, ovl_ack:3'd0, spur:1'b0,
                n_acks:0, acks:24'd0};
    vecs[1] = '{hits:8'b1010_0110, req:3'd1, states:ALL_S, ways:WAYS, addr:40'h12_3456_7840,
                exp_count:3, stall_lce:-1, ovl_send:-1, ovl_ack:3'd0, spur:1'b0,
                n_acks:3, acks:{15'd0, 3'd5, 3'd2, 3'd7}};
    vecs[2] = '{hits:8'b1010_0110, req:3'd1, states:ALL_S, ways:WAYS, addr:40'hAB_CDEF_0040,
                exp_count:3, stall_lce:5, ovl_send:-1, ovl_ack:3'd0, spur:1'b0,
                n_acks:3, acks:{15'd0, 3'd7, 3'd5, 3'd2}};
    vecs[3] = '{hits:8'b0000_1100, req:3'd0, states:24'h249049, ways:WAYS, addr:40'h00_0F00_0080,
                exp_count:1, stall_lce:-1, ovl_send:-1, ovl_ack:3'd0, spur:1'b0,
                n_acks:1, acks:{21'd0, 3'd2}};
    vecs[4] = '{hits:8'b1010_0110, req:3'd1, states:24'hDB6DB6, ways:24'hFAC688, addr:40'h55_AA55_AA00,
                exp_count:3, stall_lce:-1, ovl_send:7, ovl_ack:3'd2, spur:1'b1,
                n_acks:2, acks:{18'd0, 3'd7, 3'd5}};
    vecs[5] = '{hits:8'hFF, req:3'd0,
                states:{3'd7, 3'd6, 3'd3, 3'd2, 3'd1, 3'd1, 3'd6, 3'd3},
                ways:WAYS, addr:40'hFF_FFFF_FFC0,
                exp_count:7, stall_lce:-1, ovl_send:-1, ovl_ack:3'd0, spur:1'b0,
                n_acks:7, acks:{3'd0, 3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1}};

    bus.start_v_i            = 1'b0;
    bus.addr_i               = '0;
    bus.req_lce_i            = '0;
    bus.sharers_hits_i       = '0;
    bus.sharers_ways_i       = '0;
    bus.sharers_coh_states_i = '0;
    bus.inv_ready_and_i      = 1'b0;
    bus.ack_v_i              = 1'b0;
    bus.ack_lce_i            = '0;
    bus.done_yumi_i          = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_ready", 64'(bus.start_ready_and_o), 64'(1));
    check("rst_inv_v", 64'(bus.inv_v_o), 64'(0));
    check("rst_done",  64'(bus.done_v_o), 64'(0));
    check("rst_count", 64'(bus.inv_count_o), 64'(0));
    check("rst_busy",  64'(bus.busy_o), 64'(0));
    bus.ack_v_i = 1'b1;
    #1;
    check("rst_ack_yumi", 64'(bus.ack_yumi_o), 64'(0));
    bus.ack_v_i = 1'b0;
    @(posedge clk); #1;

    for (int k = 0; k < 6; k++) run_vec(vecs[k], 1'b0);
    run_vec(vecs[1], 1'b1);
    run_vec(vecs[3], 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Hard stop in case the sequence above stalls on a clock-edge wait.
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
